// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared exception codes, NOP and fetch-entry layout for fetch_queue
package fetch_queue_pkg;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int EXC_W   = 5;
    localparam int ENTRY_W = INSTR_W + PC_W + EXC_W;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc4;
        logic [EXC_W-1:0]   exc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - DEPTH-entry circular FIFO with push, pop, flush and occupancy count
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full queue still takes a push when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch-queue fetch stage feeding D; FETCH_ADEL_EN enables fetch address-error entries
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter int          IADDR_W      = 12,
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       StallD,
    input  logic                       exp_in,
    input  logic                       EretD,
    input  logic [31:0]                EPC,
    input  logic                       BrValid,
    input  logic [31:0]                BrTarget,
    output logic [IADDR_W-1:0]         IAddr,
    input  logic [31:0]                IData,
    output logic [31:0]                IRD,
    output logic [31:0]                PC4D,
    output logic [6:2]                 ExcCodeD,
    output logic                       bdD,
    output logic                       ValidD,
    output logic [$clog2(DEPTH+1)-1:0] QCount
);

    logic [31:0] r_pc;
    logic [31:0] r_ird;
    logic [31:0] r_pc4d;
    logic [4:0]  r_exc;
    logic        r_bd;
    logic        r_valid;

    logic [31:0]  w_off;
    logic [31:0]  w_instr;
    logic [4:0]   w_exc;
    fetch_entry_t w_fetch;
    fetch_entry_t w_head;
    fetch_entry_t w_dslot;
    logic         w_empty;
    logic         w_full;
    logic         w_eret;
    logic         w_br;
    logic         w_flush;
    logic         w_load;
    logic         w_fetch_valid;
    logic         w_push;
    logic         w_pop;

    assign w_off = r_pc - RESET_PC;
    assign IAddr = w_off[IADDR_W+1:2];

`ifdef FETCH_ADEL_EN
    localparam logic [32:0] IM_BYTES = 33'(4) << IADDR_W;
    logic w_bad;
    assign w_bad   = (r_pc[1:0] != 2'b00) || ({1'b0, w_off} >= IM_BYTES);
    assign w_instr = w_bad ? NOP : IData;
    assign w_exc   = w_bad ? EXC_ADEL : EXC_NONE;
`else
    logic w_unused_off;
    assign w_unused_off = ^{w_off[31:IADDR_W+2], w_off[1:0]};
    assign w_instr      = IData;
    assign w_exc        = EXC_NONE;
`endif

    assign w_fetch = '{instr: w_instr, pc4: r_pc + 32'd4, exc: w_exc};

    assign w_eret  = EretD & ~StallD;
    assign w_br    = BrValid & ~StallD;
    assign w_flush = exp_in | w_eret | w_br;
    assign w_load  = ~StallD;

    // With an empty queue the current fetch goes straight into D instead of being queued.
    assign w_dslot       = w_empty ? w_fetch : w_head;
    assign w_fetch_valid = ~w_full | w_load;
    assign w_pop         = w_load & ~w_empty;
    assign w_push        = w_fetch_valid & ~(w_empty & w_load) & ~w_flush;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_fetch),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (QCount)
    );

    always_ff @(posedge Clk) begin
        if (Reset)              r_pc <= RESET_PC;
        else if (exp_in)        r_pc <= HANDLER_ADDR;
        else if (w_eret)        r_pc <= EPC;
        else if (w_br)          r_pc <= BrTarget;
        else if (w_fetch_valid) r_pc <= r_pc + 32'd4;
    end

    // A taken branch still loads D normally: that instruction is its delay slot.
    always_ff @(posedge Clk) begin
        if (Reset || exp_in) begin
            r_ird   <= '0;
            r_pc4d  <= '0;
            r_exc   <= EXC_NONE;
            r_bd    <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_eret) begin
            r_ird   <= '0;
            r_pc4d  <= EPC + 32'd4;
            r_exc   <= EXC_NONE;
            r_bd    <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_ird   <= w_dslot.instr;
            r_pc4d  <= w_dslot.pc4;
            r_exc   <= w_dslot.exc;
            r_bd    <= BrValid;
            r_valid <= 1'b1;
        end
    end

    assign IRD      = r_ird;
    assign PC4D     = r_pc4d;
    assign ExcCodeD = r_exc;
    assign bdD      = r_bd;
    assign ValidD   = r_valid;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a cycle-tagged expected queue
module tb_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int IADDR_W = 12;

    logic                       Clk = 1'b0;
    logic                       Reset, StallD, exp_in, EretD, BrValid;
    logic [31:0]                EPC, BrTarget;
    logic [IADDR_W-1:0]         IAddr;
    logic [31:0]                IData;
    logic [31:0]                IRD, PC4D;
    logic [6:2]                 ExcCodeD;
    logic                       bdD, ValidD;
    logic [$clog2(DEPTH+1)-1:0] QCount;

    fetch_queue #(
        .DEPTH        (DEPTH),
        .IADDR_W      (IADDR_W),
        .RESET_PC     (32'h0000_3000),
        .HANDLER_ADDR (32'h0000_4180)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .StallD   (StallD),
        .exp_in   (exp_in),
        .EretD    (EretD),
        .EPC      (EPC),
        .BrValid  (BrValid),
        .BrTarget (BrTarget),
        .IAddr    (IAddr),
        .IData    (IData),
        .IRD      (IRD),
        .PC4D     (PC4D),
        .ExcCodeD (ExcCodeD),
        .bdD      (bdD),
        .ValidD   (ValidD),
        .QCount   (QCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] im(input int a);
        return 32'hA000_0007 | (32'(a) << 4);
    endfunction

    assign IData = im(int'(IAddr));

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] ird;
        logic [31:0] pc4;
        logic [4:0]  exc;
        logic        bd;
        logic        vld;
        int          qc;
        int          ia;
    } sb_item_t;

    sb_item_t sb[$];
    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic exp_at(input int d, input string tag, input logic [31:0] ird,
                          input logic [31:0] pc4, input logic [4:0] exc, input logic bd,
                          input logic vld, input int qc, input int ia);
        sb_item_t it;
        it.cyc = cyc + d; it.tag = tag; it.ird = ird; it.pc4 = pc4; it.exc = exc;
        it.bd = bd; it.vld = vld; it.qc = qc; it.ia = ia;
        sb.push_back(it);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        sb_item_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: check for edge %0d reached late at edge %0d, expected on time", e.tag, e.cyc, cyc);
            end else if (IRD !== e.ird || PC4D !== e.pc4 || ExcCodeD !== e.exc || bdD !== e.bd ||
                         ValidD !== e.vld || (e.qc >= 0 && int'(QCount) != e.qc) ||
                         (e.ia >= 0 && int'(IAddr) != e.ia)) begin
                n_bad++;
                $display("FAIL %s @edge %0d: got IRD=%h PC4D=%h Exc=%0d bd=%b V=%b Q=%0d IA=%0h, expected IRD=%h PC4D=%h Exc=%0d bd=%b V=%b Q=%0d IA=%0h",
                         e.tag, cyc, IRD, PC4D, ExcCodeD, bdD, ValidD, QCount, IAddr,
                         e.ird, e.pc4, e.exc, e.bd, e.vld, e.qc, e.ia);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; StallD = 1'b0; exp_in = 1'b0; EretD = 1'b0; BrValid = 1'b0;
        EPC = '0; BrTarget = '0;
        tick(); tick();
        exp_at(0, "reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 0, 0);

        Reset = 1'b0;
        exp_at(1, "first_bypass", im(0), 32'h3004, 5'd0, 1'b0, 1'b1, 0, 1);
        tick();
        exp_at(1, "second_fetch", im(1), 32'h3008, 5'd0, 1'b0, 1'b1, 0, 2);
        tick();

        Reset = 1'b1; tick(); Reset = 1'b0;
        exp_at(1, "stall_pre", im(0), 32'h3004, 5'd0, 1'b0, 1'b1, 0, 1);
        tick();
        StallD = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            int q;
            q = (i < DEPTH) ? i : DEPTH;
            exp_at(1, $sformatf("stall_fill%0d", i), im(0), 32'h3004, 5'd0, 1'b0, 1'b1, q, 1 + q);
            tick();
        end
        StallD = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            exp_at(1, $sformatf("drain%0d", i), im(i), 32'h3000 + 32'(4 * (i + 1)), 5'd0,
                   1'b0, 1'b1, DEPTH, 5 + i);
            tick();
        end

        Reset = 1'b1; tick(); Reset = 1'b0;
        exp_at(1, "br_pre", im(0), 32'h3004, 5'd0, 1'b0, 1'b1, 0, 1);
        tick();
        StallD = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_at(1, $sformatf("br_fill%0d", i), im(0), 32'h3004, 5'd0, 1'b0, 1'b1, i, 1 + i);
            tick();
        end
        StallD = 1'b0; BrValid = 1'b1; BrTarget = 32'h3100;
        exp_at(1, "br_delay_slot", im(1), 32'h3008, 5'd0, 1'b1, 1'b1, 0, 32'h40);
        tick();
        BrValid = 1'b0;
        exp_at(1, "br_target", im(32'h40), 32'h3104, 5'd0, 1'b0, 1'b1, 0, 32'h41);
        tick();

        StallD = 1'b1; exp_in = 1'b1;
        exp_at(1, "exc_clear", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 0, 32'h460);
        tick();
        exp_in = 1'b0; StallD = 1'b0;
        exp_at(1, "exc_handler", im(32'h460), 32'h4184, 5'd0, 1'b0, 1'b1, 0, 32'h461);
        tick();

        StallD = 1'b1;
        exp_at(1, "eret_fill1", im(32'h460), 32'h4184, 5'd0, 1'b0, 1'b1, 1, 32'h462);
        tick();
        exp_at(1, "eret_fill2", im(32'h460), 32'h4184, 5'd0, 1'b0, 1'b1, 2, 32'h463);
        tick();
        StallD = 1'b0; EretD = 1'b1; BrValid = 1'b1; EPC = 32'h3008; BrTarget = 32'h3100;
        exp_at(1, "eret_wins", 32'h0, 32'h300c, 5'd0, 1'b0, 1'b0, 0, 2);
        tick();
        EretD = 1'b0; BrValid = 1'b0;
        exp_at(1, "eret_return", im(2), 32'h300c, 5'd0, 1'b0, 1'b1, 0, 3);
        tick();

        BrValid = 1'b1; BrTarget = 32'h3002;
        exp_at(1, "misalign_slot", im(3), 32'h3010, 5'd0, 1'b1, 1'b1, 0, 0);
        tick();
        BrValid = 1'b0;
`ifdef FETCH_ADEL_EN
        exp_at(1, "misalign_fetch", 32'h0, 32'h3006, 5'd4, 1'b0, 1'b1, 0, -1);
`else
        exp_at(1, "misalign_fetch", im(0), 32'h3006, 5'd0, 1'b0, 1'b1, 0, -1);
`endif
        tick();

        tick(); tick();
        while (sb.size() > 0) begin
            sb_item_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: check for edge %0d never evaluated, expected by edge %0d", e.tag, e.cyc, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
